// File: rtl/mips_pkg.sv
// Shared multiply/divide definitions: one-hot unit op codes, the HI/LO
// controller state encoding and small op-decode helpers.
package mips_pkg;

    // One-hot multiply/divide op codes as presented to the unit
    localparam logic [3:0] MD_DIV_S = 4'b0001;
    localparam logic [3:0] MD_DIV_U = 4'b0010;
    localparam logic [3:0] MD_MUL_S = 4'b0100;
    localparam logic [3:0] MD_MUL_U = 4'b1000;

    // Controller states
    typedef enum logic [1:0] {
        MD_IDLE      = 2'd0,
        MD_MUL_WAIT  = 2'd1,
        MD_DIV_WAIT  = 2'd2,
        MD_DIV_DRAIN = 2'd3
    } md_state_e;

    // True when exactly one op bit is set
    function automatic logic md_is_onehot(input logic [3:0] op);
        return (op != 4'd0) && ((op & (op - 4'd1)) == 4'd0);
    endfunction

    // True for either multiply flavour
    function automatic logic md_is_mul(input logic [3:0] op);
        return op[2] | op[3];
    endfunction

endpackage

// File: rtl/hilo_regfile.sv
// Architectural HI/LO register pair.
// Ports:
//   clk, reset      clock, synchronous active-high reset (clears HI/LO)
//   hi_we, lo_we    per-register write enables
//   hi_wd, lo_wd    write data
//   rd_hi           read select: 1 = HI, 0 = LO
//   hi, lo          current register values
//   rdata           selected register value
module hilo_regfile #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] hi_wd,
    input  logic [DATA_W-1:0] lo_wd,
    input  logic              rd_hi,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] rdata
);

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (hi_we) hi <= hi_wd;
            if (lo_we) lo <= lo_wd;
        end
    end

    assign rdata = rd_hi ? hi : lo;

endmodule

// File: rtl/md_hilo_ctrl.sv
// Execute-stage controller around the multiply/divide unit. Decodes the
// issuing op, drives the unit request, captures the 64-bit result into
// HI/LO, serves MFHI/MFLO/MTHI/MTLO and stalls execute while a result is
// outstanding.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   ex_valid              execute-stage instruction valid
//   ex_md_op              one-hot {multu, mult, divu, div}
//   ex_mthi/mtlo/mfhi/mflo  HI/LO move instructions in execute
//   ex_src1, ex_src2      rs / rt operands
//   flush                 execute-stage flush (exception/eret)
//   md_op, md_src1/2      request to the multiply/divide unit
//   md_result, md_en      unit result {HI, LO} and its valid strobe
//   stall                 hold the execute stage
//   mf_data               MFHI/MFLO read data (0 when no MF* active)
//   hi, lo                architectural HI/LO
//   busy                  an op is outstanding
module md_hilo_ctrl
    import mips_pkg::*;
#(
    parameter int MUL_LAT = 1,
    parameter int DATA_W  = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ex_valid,
    input  logic [3:0]          ex_md_op,
    input  logic                ex_mthi,
    input  logic                ex_mtlo,
    input  logic                ex_mfhi,
    input  logic                ex_mflo,
    input  logic [DATA_W-1:0]   ex_src1,
    input  logic [DATA_W-1:0]   ex_src2,
    input  logic                flush,
    output logic [3:0]          md_op,
    output logic [DATA_W-1:0]   md_src1,
    output logic [DATA_W-1:0]   md_src2,
    input  logic [2*DATA_W-1:0] md_result,
    input  logic                md_en,
    output logic                stall,
    output logic [DATA_W-1:0]   mf_data,
    output logic [DATA_W-1:0]   hi,
    output logic [DATA_W-1:0]   lo,
    output logic                busy
);

    md_state_e         state_q;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] src1_q;
    logic [DATA_W-1:0] src2_q;

    logic legal_op, issue, in_wait, fwd_ok, res_wr, mt_ok, mf_req;
    logic hi_we, lo_we;
    logic [DATA_W-1:0] hi_wd, lo_wd, rf_rdata;

    assign legal_op = ex_valid && md_is_onehot(ex_md_op) && !flush;
    assign issue    = (state_q == MD_IDLE) && legal_op;
    // A live (not flushed) result is expected only in the two wait states
    assign in_wait  = (state_q == MD_MUL_WAIT) || (state_q == MD_DIV_WAIT);
    assign fwd_ok   = in_wait && md_en && !flush;
    assign res_wr   = fwd_ok;
    assign mt_ok    = (state_q == MD_IDLE) && ex_valid && !flush;
    assign mf_req   = ex_valid && (ex_mfhi || ex_mflo);
    assign busy     = (state_q != MD_IDLE);

    // ---------------- FSM and held request ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            op_q    <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (legal_op) begin
                        op_q    <= ex_md_op;
                        src1_q  <= ex_src1;
                        src2_q  <= ex_src2;
                        state_q <= md_is_mul(ex_md_op) ? MD_MUL_WAIT : MD_DIV_WAIT;
                    end
                end
                MD_MUL_WAIT: begin
                    if (md_en || flush) state_q <= MD_IDLE;
                end
                MD_DIV_WAIT: begin
                    if (md_en)      state_q <= MD_IDLE;
                    else if (flush) state_q <= MD_DIV_DRAIN;
                end
                MD_DIV_DRAIN: begin
                    if (md_en) state_q <= MD_IDLE;
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    // ---------------- unit request ----------------
    // Issue goes out combinationally; the divider then needs the request
    // level-held from the latched copy until it answers.
    always_comb begin
        md_op   = '0;
        md_src1 = src1_q;
        md_src2 = src2_q;
        case (state_q)
            MD_IDLE: begin
                if (issue) begin
                    md_op   = ex_md_op;
                    md_src1 = ex_src1;
                    md_src2 = ex_src2;
                end
            end
            MD_DIV_WAIT, MD_DIV_DRAIN: md_op = md_en ? 4'd0 : op_q;
            default: md_op = '0;
        endcase
    end

    // ---------------- stall ----------------
    // MF* in the result cycle is satisfied by forwarding; anything that
    // would issue or write HI/LO still waits one cycle.
    always_comb begin
        stall = 1'b0;
        if (busy && ex_valid) begin
            if ((ex_md_op != 4'd0) || ex_mthi || ex_mtlo)
                stall = 1'b1;
            else if ((ex_mfhi || ex_mflo) && !fwd_ok)
                stall = 1'b1;
        end
    end

    // ---------------- HI/LO writes ----------------
    // Result writes only happen outside IDLE and MT* writes only in IDLE,
    // so the two sources never collide.
    assign hi_we = res_wr || (mt_ok && ex_mthi);
    assign lo_we = res_wr || (mt_ok && ex_mtlo);
    assign hi_wd = res_wr ? md_result[2*DATA_W-1:DATA_W] : ex_src1;
    assign lo_wd = res_wr ? md_result[DATA_W-1:0]        : ex_src1;

    hilo_regfile #(.DATA_W(DATA_W)) u_hilo (
        .clk   (clk),
        .reset (reset),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .hi_wd (hi_wd),
        .lo_wd (lo_wd),
        .rd_hi (ex_mfhi),
        .hi    (hi),
        .lo    (lo),
        .rdata (rf_rdata)
    );

    // ---------------- MF read data ----------------
    always_comb begin
        mf_data = '0;
        if (mf_req) begin
            if (fwd_ok)
                mf_data = ex_mfhi ? md_result[2*DATA_W-1:DATA_W] : md_result[DATA_W-1:0];
            else
                mf_data = rf_rdata;
        end
    end

`ifndef SYNTHESIS
    // Cycles spent in MUL_WAIT, 1 on the first cycle after issue
    int mul_age;
    always_ff @(posedge clk) begin
        if (reset || state_q != MD_MUL_WAIT) mul_age <= 1;
        else                                mul_age <= mul_age + 1;
    end

    a_md_op_onehot: assert property (@(posedge clk) disable iff (reset)
        (ex_valid && ex_md_op != 4'd0) |-> md_is_onehot(ex_md_op));

    a_md_en_stray: assert property (@(posedge clk) disable iff (reset)
        md_en |-> (state_q != MD_IDLE));

    a_mul_latency: assert property (@(posedge clk) disable iff (reset)
        (state_q == MD_MUL_WAIT && !flush && mul_age >= MUL_LAT) |-> md_en);
`endif

endmodule

// File: tb/tb_md_hilo_ctrl.sv
module tb_md_hilo_ctrl;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [3:0]  ex_md_op;
    logic        ex_mthi, ex_mtlo, ex_mfhi, ex_mflo;
    logic [31:0] ex_src1, ex_src2;
    logic        flush;
    logic [3:0]  md_op;
    logic [31:0] md_src1, md_src2;
    logic [63:0] md_result;
    logic        md_en;
    logic        stall;
    logic [31:0] mf_data, hi, lo;
    logic        busy;

    md_hilo_ctrl #(.MUL_LAT(1), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_md_op(ex_md_op),
        .ex_mthi(ex_mthi), .ex_mtlo(ex_mtlo), .ex_mfhi(ex_mfhi), .ex_mflo(ex_mflo),
        .ex_src1(ex_src1), .ex_src2(ex_src2), .flush(flush),
        .md_op(md_op), .md_src1(md_src1), .md_src2(md_src2),
        .md_result(md_result), .md_en(md_en), .stall(stall),
        .mf_data(mf_data), .hi(hi), .lo(lo), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_idle();
        ex_valid  = 1'b0; ex_md_op = 4'd0;
        ex_mthi   = 1'b0; ex_mtlo  = 1'b0; ex_mfhi = 1'b0; ex_mflo = 1'b0;
        ex_src1   = 32'd0; ex_src2 = 32'd0;
        flush     = 1'b0; md_en    = 1'b0; md_result = 64'd0;
    endtask

    // Advance through the active edge; return on the following negedge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // IDLE-state MT/MF vectors applied from reset (hi=lo=0)
    typedef struct {
        logic        v, mthi, mtlo, mfhi, mflo, fl;
        logic [31:0] s1;
        logic [31:0] e_mf;
        logic        e_stall;
        logic [31:0] e_hi, e_lo;
    } vec_t;
    vec_t tbl[9];

    // Reference model state
    logic [31:0] m_hi, m_lo;
    bit          p_act, p_mul, p_doom;
    logic [3:0]  p_op;
    logic [31:0] p_s1, p_s2;
    int          p_age;

    initial begin
        set_idle();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // ---------------- reset state ----------------
        #1;
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_busy", busy, 0);
        chk("reset_stall", stall, 0);
        chk("reset_md_op", md_op, 0);

        // ---------------- table: IDLE MT/MF ----------------
        tbl[0] = '{1,0,0,1,0,0, 32'h0,         32'h0,     0, 32'h0,    32'h0};
        tbl[1] = '{1,1,0,0,0,0, 32'h1234,      32'h0,     0, 32'h1234, 32'h0};
        tbl[2] = '{1,0,1,0,0,1, 32'hABCD,      32'h0,     0, 32'h1234, 32'h0};
        tbl[3] = '{1,0,1,0,0,0, 32'hABCD,      32'h0,     0, 32'h1234, 32'hABCD};
        tbl[4] = '{1,0,0,1,0,0, 32'h0,         32'h1234,  0, 32'h1234, 32'hABCD};
        tbl[5] = '{1,0,0,0,1,0, 32'h0,         32'hABCD,  0, 32'h1234, 32'hABCD};
        tbl[6] = '{0,1,0,0,0,0, 32'h5555,      32'h0,     0, 32'h1234, 32'hABCD};
        tbl[7] = '{0,0,0,0,1,0, 32'h0,         32'h0,     0, 32'h1234, 32'hABCD};
        tbl[8] = '{1,0,0,1,0,1, 32'h0,         32'h1234,  0, 32'h1234, 32'hABCD};
        for (int i = 0; i < 9; i++) begin
            set_idle();
            ex_valid = tbl[i].v;  ex_mthi = tbl[i].mthi; ex_mtlo = tbl[i].mtlo;
            ex_mfhi  = tbl[i].mfhi; ex_mflo = tbl[i].mflo; flush = tbl[i].fl;
            ex_src1  = tbl[i].s1;
            #1;
            chk($sformatf("tbl%0d_mf", i), mf_data, tbl[i].e_mf);
            chk($sformatf("tbl%0d_stall", i), stall, tbl[i].e_stall);
            step();
            chk($sformatf("tbl%0d_hi", i), hi, tbl[i].e_hi);
            chk($sformatf("tbl%0d_lo", i), lo, tbl[i].e_lo);
        end

        // ---------------- MULT with forwarding ----------------
        set_idle();
        ex_valid = 1; ex_md_op = MD_MUL_S; ex_src1 = 32'hFFFF_FFFF; ex_src2 = 32'd2;
        #1;
        chk("mul_issue_op", md_op, MD_MUL_S);
        chk("mul_issue_src1", md_src1, 32'hFFFF_FFFF);
        chk("mul_issue_src2", md_src2, 32'd2);
        chk("mul_issue_stall", stall, 0);
        step();
        set_idle();
        ex_valid = 1; ex_mflo = 1; md_en = 1; md_result = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        chk("mul_fwd_busy", busy, 1);
        chk("mul_fwd_op", md_op, 0);
        chk("mul_fwd_stall", stall, 0);
        chk("mul_fwd_mf", mf_data, 32'hFFFF_FFFE);
        step();
        set_idle();
        #1;
        chk("mul_hi", hi, 32'hFFFF_FFFF);
        chk("mul_lo", lo, 32'hFFFF_FFFE);
        chk("mul_done_busy", busy, 0);

        // ---------------- DIVU 100/7, 33-cycle completion ----------------
        ex_valid = 1; ex_md_op = MD_DIV_U; ex_src1 = 32'd100; ex_src2 = 32'd7;
        #1;
        chk("divu_issue_op", md_op, MD_DIV_U);
        chk("divu_issue_stall", stall, 0);
        step();
        for (int k = 1; k <= 33; k++) begin
            set_idle();
            ex_valid = 1; ex_mfhi = 1;
            if (k == 33) begin md_en = 1; md_result = {32'd2, 32'd14}; end
            #1;
            if (k < 33) begin
                chk($sformatf("divu_hold_op_%0d", k), md_op, MD_DIV_U);
                chk($sformatf("divu_hold_src1_%0d", k), md_src1, 32'd100);
                chk($sformatf("divu_mfhi_stall_%0d", k), stall, 1);
            end else begin
                chk("divu_done_op", md_op, 0);
                chk("divu_done_stall", stall, 0);
                chk("divu_fwd_mf", mf_data, 32'd2);
            end
            step();
        end
        set_idle();
        #1;
        chk("divu_hi", hi, 32'd2);
        chk("divu_lo", lo, 32'd14);
        chk("divu_busy", busy, 0);

        // ---------------- DIV flushed at cycle 5 -> drain ----------------
        ex_valid = 1; ex_md_op = MD_DIV_S; ex_src1 = 32'd50; ex_src2 = 32'd5;
        step();
        for (int k = 1; k <= 5; k++) begin
            set_idle();
            if (k == 5) flush = 1;
            #1;
            chk($sformatf("div_pre_flush_op_%0d", k), md_op, MD_DIV_S);
            step();
        end
        set_idle();
        ex_valid = 1; ex_mthi = 1; ex_src1 = 32'h7777;
        #1;
        chk("drain_busy", busy, 1);
        chk("drain_stall", stall, 1);
        chk("drain_op_held", md_op, MD_DIV_S);
        step();
        md_en = 1; md_result = 64'hDEAD_BEEF_0BAD_F00D;
        #1;
        chk("drain_en_stall", stall, 1);
        step();
        set_idle();
        #1;
        chk("drain_done_busy", busy, 0);
        chk("drain_hi", hi, 32'd2);
        chk("drain_lo", lo, 32'd14);

        // ---------------- DIVU with flush and md_en together ----------------
        ex_valid = 1; ex_md_op = MD_DIV_U; ex_src1 = 32'd9; ex_src2 = 32'd3;
        step();
        set_idle();
        ex_valid = 1; ex_mflo = 1; flush = 1; md_en = 1; md_result = {32'hAAAA, 32'hBBBB};
        #1;
        chk("flush_en_stall", stall, 1);
        step();
        set_idle();
        #1;
        chk("flush_en_busy", busy, 0);
        chk("flush_en_hi", hi, 32'd2);
        chk("flush_en_lo", lo, 32'd14);

        // ---------------- MULTU in flight, DIVU behind it ----------------
        ex_valid = 1; ex_md_op = MD_MUL_U; ex_src1 = 32'd3; ex_src2 = 32'd5;
        step();
        set_idle();
        ex_valid = 1; ex_md_op = MD_DIV_U; ex_src1 = 32'd15; ex_src2 = 32'd4;
        md_en = 1; md_result = {32'd0, 32'd15};
        #1;
        chk("b2b_stall", stall, 1);
        chk("b2b_op_blocked", md_op, 0);
        step();
        md_en = 0; md_result = 64'd0;
        #1;
        chk("b2b_hi", hi, 32'd0);
        chk("b2b_lo", lo, 32'd15);
        chk("b2b_issue_stall", stall, 0);
        chk("b2b_issue_op", md_op, MD_DIV_U);
        chk("b2b_issue_src2", md_src2, 32'd4);
        step();
        set_idle();
        md_en = 1; md_result = {32'd3, 32'd3};
        step();
        set_idle();
        #1;
        chk("b2b_div_hi", hi, 32'd3);
        chk("b2b_div_lo", lo, 32'd3);

        // ---------------- reset mid-divide ----------------
        ex_valid = 1; ex_md_op = MD_DIV_S; ex_src1 = 32'd77; ex_src2 = 32'd0;
        step();
        set_idle();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        chk("midrst_op", md_op, 0);

        // ---------------- randomized vs reference model ----------------
        m_hi = 0; m_lo = 0; p_act = 0; p_mul = 0; p_doom = 0;
        p_op = 0; p_s1 = 0; p_s2 = 0; p_age = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int kind;
            logic        fwd, mf, e_stall;
            logic [3:0]  e_op;
            logic [31:0] e_mf;
            logic [31:0] e_s1, e_s2;
            set_idle();
            ex_valid = ($urandom % 4) != 0;
            kind = int'($urandom % 8);
            case (kind)
                1: ex_md_op = 4'(1 << ($urandom % 4));
                2: ex_mthi = 1;
                3: ex_mtlo = 1;
                4: ex_mfhi = 1;
                5: ex_mflo = 1;
                default: ;
            endcase
            ex_src1 = ($urandom % 2) ? $urandom : ($urandom % 16);
            ex_src2 = ($urandom % 2) ? $urandom : ($urandom % 16);
            flush = ($urandom % 10) == 0;
            if (p_act && p_mul)  md_en = 1;
            else if (p_act)      md_en = (p_age >= 2 && ($urandom % 6) == 0) || p_age >= 20;
            md_result = {$urandom, $urandom};

            // Expectations from the architectural rules
            fwd = p_act && !p_doom && md_en && !flush;
            mf  = ex_valid && (ex_mfhi || ex_mflo);
            e_stall = p_act && ex_valid &&
                      ((ex_md_op != 0) || ex_mthi || ex_mtlo || (mf && !fwd));
            e_s1 = p_s1; e_s2 = p_s2;
            if (!p_act) begin
                e_op = (ex_valid && !flush && $onehot(ex_md_op)) ? ex_md_op : 4'd0;
                e_s1 = ex_src1; e_s2 = ex_src2;
            end else if (p_mul || md_en) e_op = 4'd0;
            else                         e_op = p_op;
            #1;
            chk("rnd_busy", busy, p_act);
            chk("rnd_stall", stall, e_stall);
            chk("rnd_md_op", md_op, e_op);
            if (e_op != 0) begin
                chk("rnd_src1", md_src1, e_s1);
                chk("rnd_src2", md_src2, e_s2);
            end
            if (!mf || fwd || !p_act) begin
                if (!mf)      e_mf = 0;
                else if (fwd) e_mf = ex_mfhi ? md_result[63:32] : md_result[31:0];
                else          e_mf = ex_mfhi ? m_hi : m_lo;
                chk("rnd_mf", mf_data, e_mf);
            end
            chk("rnd_hi", hi, m_hi);
            chk("rnd_lo", lo, m_lo);

            // Advance the model over this edge
            if (p_act) begin
                p_age++;
                if (md_en) begin
                    if (!flush && !p_doom) begin
                        m_hi = md_result[63:32];
                        m_lo = md_result[31:0];
                    end
                    p_act = 0;
                end else if (flush) begin
                    if (p_mul) p_act = 0;
                    else       p_doom = 1;
                end
            end else if (ex_valid && !flush) begin
                if (ex_mthi) m_hi = ex_src1;
                if (ex_mtlo) m_lo = ex_src1;
                if ($onehot(ex_md_op)) begin
                    p_act = 1; p_doom = 0; p_age = 0;
                    p_mul = ex_md_op[2] | ex_md_op[3];
                    p_op = ex_md_op; p_s1 = ex_src1; p_s2 = ex_src2;
                end
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
